// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch instruction buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: predictor/datapath widths, fetch/decode widths, fetch_entry_t record.
package fetch_buffer_pkg;

  localparam int SIZE         = 32;
  localparam int ENTRIES      = 32;
  localparam int INDEX_WIDTH  = $clog2(ENTRIES);
  localparam int GH_WIDTH     = INDEX_WIDTH + 3;

  localparam int FETCH_WIDTH  = 5;
  localparam int DECODE_WIDTH = 3;

  // One buffered instruction with its prediction metadata.
  typedef struct packed {
    logic [SIZE-1:0]     instruction;
    logic [SIZE-1:0]     pc;
    logic [SIZE-1:0]     imm;
    logic [SIZE-1:0]     pc_at_prediction;
    logic                branch_prediction;
    logic [GH_WIDTH-1:0] global_history;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_compactor.sv
// Maps a 5-bit fetch valid mask to per-slot write offsets and a write count.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the bundle is accepted.
// Ports: valid (slot mask), offset (per-slot position among valid slots), n_wr (popcount).
module fetch_slot_compactor (
  input  logic [4:0]      valid,
  output logic [4:0][2:0] offset,
  output logic [2:0]      n_wr
);
  import fetch_buffer_pkg::*;

  logic [2:0] run;

  // offset[k] = number of valid slots below k, so valid slots pack densely
  // in slot order regardless of holes in the mask.
  always_comb begin
    run    = 3'd0;
    offset = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      offset[k] = run;
      run       = run + {2'b00, valid[k]};
    end
    n_wr = run;
  end

endmodule

// File: rtl/fetch_instruction_buffer.sv
// Circular buffer between 5-wide fetch and 3-wide decode; flushed wholesale on mispredict.
// Latency: entry written in cycle N is visible to decode in cycle N+1 (no bypass).
// Backpressure: fetch_ready_o only when >=5 free slots on the registered count; decode_ready_i consumes all shown slots.
// Ports: clk/reset (sync, active-high); fetch side *_i_0..4 + fetch_valid_i/fetch_ready_o;
//        decode side *_o_0..2 + decode_valid_o/decode_ready_i; flush_i; occupancy_o.
module fetch_instruction_buffer #(
  parameter int size        = 32,
  parameter int ENTRIES     = 32,
  parameter int INDEX_WIDTH = $clog2(ENTRIES),
  parameter int GH_WIDTH    = INDEX_WIDTH + 3,
  parameter int DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [size-1:0]          instruction_i_0,
  input  logic [size-1:0]          instruction_i_1,
  input  logic [size-1:0]          instruction_i_2,
  input  logic [size-1:0]          instruction_i_3,
  input  logic [size-1:0]          instruction_i_4,
  input  logic [size-1:0]          pc_i_0,
  input  logic [size-1:0]          pc_i_1,
  input  logic [size-1:0]          pc_i_2,
  input  logic [size-1:0]          pc_i_3,
  input  logic [size-1:0]          pc_i_4,
  input  logic [size-1:0]          imm_i_0,
  input  logic [size-1:0]          imm_i_1,
  input  logic [size-1:0]          imm_i_2,
  input  logic [size-1:0]          imm_i_3,
  input  logic [size-1:0]          imm_i_4,
  input  logic [size-1:0]          pc_at_prediction_i_0,
  input  logic [size-1:0]          pc_at_prediction_i_1,
  input  logic [size-1:0]          pc_at_prediction_i_2,
  input  logic [size-1:0]          pc_at_prediction_i_3,
  input  logic [size-1:0]          pc_at_prediction_i_4,
  input  logic                     branch_prediction_i_0,
  input  logic                     branch_prediction_i_1,
  input  logic                     branch_prediction_i_2,
  input  logic                     branch_prediction_i_3,
  input  logic                     branch_prediction_i_4,
  input  logic [GH_WIDTH-1:0]      global_history_i_0,
  input  logic [GH_WIDTH-1:0]      global_history_i_1,
  input  logic [GH_WIDTH-1:0]      global_history_i_2,
  input  logic [GH_WIDTH-1:0]      global_history_i_3,
  input  logic [GH_WIDTH-1:0]      global_history_i_4,
  input  logic                     flush_i,
  output logic [2:0]               decode_valid_o,
  input  logic                     decode_ready_i,
  output logic [size-1:0]          instruction_o_0,
  output logic [size-1:0]          instruction_o_1,
  output logic [size-1:0]          instruction_o_2,
  output logic [size-1:0]          pc_o_0,
  output logic [size-1:0]          pc_o_1,
  output logic [size-1:0]          pc_o_2,
  output logic [size-1:0]          imm_o_0,
  output logic [size-1:0]          imm_o_1,
  output logic [size-1:0]          imm_o_2,
  output logic [size-1:0]          pc_at_prediction_o_0,
  output logic [size-1:0]          pc_at_prediction_o_1,
  output logic [size-1:0]          pc_at_prediction_o_2,
  output logic                     branch_prediction_o_0,
  output logic                     branch_prediction_o_1,
  output logic                     branch_prediction_o_2,
  output logic [GH_WIDTH-1:0]      global_history_o_0,
  output logic [GH_WIDTH-1:0]      global_history_o_1,
  output logic [GH_WIDTH-1:0]      global_history_o_2,
  output logic [$clog2(DEPTH):0]   occupancy_o
);
  import fetch_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  fetch_entry_t        wr_ent [FETCH_WIDTH];
  fetch_entry_t        rd_ent [DECODE_WIDTH];
  logic [4:0][2:0]     wr_off;
  logic [2:0]          n_wr;
  logic [2:0]          n_wr_eff;
  logic                wr_en;
  logic                rd_en;
  logic [1:0]          n_avail;
  logic [1:0]          n_rd;

  fetch_slot_compactor u_compactor (
    .valid  (fetch_valid_i),
    .offset (wr_off),
    .n_wr   (n_wr)
  );

  always_comb begin
    wr_ent[0] = '{instruction_i_0, pc_i_0, imm_i_0, pc_at_prediction_i_0, branch_prediction_i_0, global_history_i_0};
    wr_ent[1] = '{instruction_i_1, pc_i_1, imm_i_1, pc_at_prediction_i_1, branch_prediction_i_1, global_history_i_1};
    wr_ent[2] = '{instruction_i_2, pc_i_2, imm_i_2, pc_at_prediction_i_2, branch_prediction_i_2, global_history_i_2};
    wr_ent[3] = '{instruction_i_3, pc_i_3, imm_i_3, pc_at_prediction_i_3, branch_prediction_i_3, global_history_i_3};
    wr_ent[4] = '{instruction_i_4, pc_i_4, imm_i_4, pc_at_prediction_i_4, branch_prediction_i_4, global_history_i_4};
  end

  // Ready looks only at the registered count so fetch never sees a path
  // through decode_ready_i; space freed by a same-cycle dequeue is ignored.
  assign fetch_ready_o = ~reset & (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign wr_en         = fetch_ready_o & ~flush_i;
  assign n_wr_eff      = wr_en ? n_wr : 3'd0;

  always_comb begin
    n_avail = (count >= CNT_W'(DECODE_WIDTH)) ? 2'd3 : count[1:0];
  end

  assign rd_en = decode_ready_i & ~flush_i & ~reset;
  assign n_rd  = rd_en ? n_avail : 2'd0;

  always_comb begin
    decode_valid_o = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      decode_valid_o[j] = (2'(j) < n_avail) & ~flush_i & ~reset;
      rd_ent[j]         = decode_valid_o[j] ? mem[head + PTR_W'(j)] : '0;
    end
  end

  assign occupancy_o = reset ? '0 : count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_rd);
      tail  <= tail + PTR_W'(n_wr_eff);
      count <= count + CNT_W'(n_wr_eff) - CNT_W'(n_rd);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (fetch_valid_i[k]) begin
          mem[tail + PTR_W'(wr_off[k])] <= wr_ent[k];
        end
      end
    end
  end

  assign instruction_o_0       = rd_ent[0].instruction;
  assign instruction_o_1       = rd_ent[1].instruction;
  assign instruction_o_2       = rd_ent[2].instruction;
  assign pc_o_0                = rd_ent[0].pc;
  assign pc_o_1                = rd_ent[1].pc;
  assign pc_o_2                = rd_ent[2].pc;
  assign imm_o_0               = rd_ent[0].imm;
  assign imm_o_1               = rd_ent[1].imm;
  assign imm_o_2               = rd_ent[2].imm;
  assign pc_at_prediction_o_0  = rd_ent[0].pc_at_prediction;
  assign pc_at_prediction_o_1  = rd_ent[1].pc_at_prediction;
  assign pc_at_prediction_o_2  = rd_ent[2].pc_at_prediction;
  assign branch_prediction_o_0 = rd_ent[0].branch_prediction;
  assign branch_prediction_o_1 = rd_ent[1].branch_prediction;
  assign branch_prediction_o_2 = rd_ent[2].branch_prediction;
  assign global_history_o_0    = rd_ent[0].global_history;
  assign global_history_o_1    = rd_ent[1].global_history;
  assign global_history_o_2    = rd_ent[2].global_history;

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
module tb_fetch_instruction_buffer;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pap;
    logic        bp;
    logic [7:0]  gh;
  } tb_ent_t;

  typedef struct {
    logic [4:0] mask;
    logic [4:0] bpm;
    logic       rdy;
    int         occ;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [2:0]  decode_valid;
  logic        decode_ready;
  logic [4:0]  occupancy;

  logic [31:0] ins_i [5];
  logic [31:0] pc_i  [5];
  logic [31:0] imm_i [5];
  logic [31:0] pap_i [5];
  logic        bp_i  [5];
  logic [7:0]  gh_i  [5];
  logic [31:0] ins_o [3];
  logic [31:0] pc_o  [3];
  logic [31:0] imm_o [3];
  logic [31:0] pap_o [3];
  logic        bp_o  [3];
  logic [7:0]  gh_o  [3];

  int          checks = 0;
  int          errors = 0;
  int unsigned base_pc = 0;
  tb_ent_t     mq[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  fetch_instruction_buffer dut (
    .clk(clk), .reset(reset),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .instruction_i_0(ins_i[0]), .instruction_i_1(ins_i[1]), .instruction_i_2(ins_i[2]),
    .instruction_i_3(ins_i[3]), .instruction_i_4(ins_i[4]),
    .pc_i_0(pc_i[0]), .pc_i_1(pc_i[1]), .pc_i_2(pc_i[2]), .pc_i_3(pc_i[3]), .pc_i_4(pc_i[4]),
    .imm_i_0(imm_i[0]), .imm_i_1(imm_i[1]), .imm_i_2(imm_i[2]), .imm_i_3(imm_i[3]), .imm_i_4(imm_i[4]),
    .pc_at_prediction_i_0(pap_i[0]), .pc_at_prediction_i_1(pap_i[1]), .pc_at_prediction_i_2(pap_i[2]),
    .pc_at_prediction_i_3(pap_i[3]), .pc_at_prediction_i_4(pap_i[4]),
    .branch_prediction_i_0(bp_i[0]), .branch_prediction_i_1(bp_i[1]), .branch_prediction_i_2(bp_i[2]),
    .branch_prediction_i_3(bp_i[3]), .branch_prediction_i_4(bp_i[4]),
    .global_history_i_0(gh_i[0]), .global_history_i_1(gh_i[1]), .global_history_i_2(gh_i[2]),
    .global_history_i_3(gh_i[3]), .global_history_i_4(gh_i[4]),
    .flush_i(flush), .decode_valid_o(decode_valid), .decode_ready_i(decode_ready),
    .instruction_o_0(ins_o[0]), .instruction_o_1(ins_o[1]), .instruction_o_2(ins_o[2]),
    .pc_o_0(pc_o[0]), .pc_o_1(pc_o[1]), .pc_o_2(pc_o[2]),
    .imm_o_0(imm_o[0]), .imm_o_1(imm_o[1]), .imm_o_2(imm_o[2]),
    .pc_at_prediction_o_0(pap_o[0]), .pc_at_prediction_o_1(pap_o[1]), .pc_at_prediction_o_2(pap_o[2]),
    .branch_prediction_o_0(bp_o[0]), .branch_prediction_o_1(bp_o[1]), .branch_prediction_o_2(bp_o[2]),
    .global_history_o_0(gh_o[0]), .global_history_o_1(gh_o[1]), .global_history_o_2(gh_o[2]),
    .occupancy_o(occupancy)
  );

  function automatic tb_ent_t mk(input int unsigned pc, input logic bp);
    tb_ent_t     e;
    logic [31:0] p;
    p        = pc;
    e.pc     = p;
    e.ins    = p ^ 32'hDEAD_0013;
    e.imm    = p * 3 + 32'd7;
    e.pap    = p + 32'h0000_1000;
    e.bp     = bp;
    e.gh     = p[9:2] ^ 8'h5A;
    return e;
  endfunction

  function automatic logic [159:0] pack(input tb_ent_t e);
    return {23'd0, e.ins, e.pc, e.imm, e.pap, e.bp, e.gh};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs against the
  // scoreboard before the edge, advance the scoreboard, then cross the edge.
  task automatic step(input logic rst, input logic [4:0] mask, input logic [4:0] bpm,
                      input logic rdy, input logic fl);
    tb_ent_t     ents [5];
    logic        exp_rdy;
    logic [2:0]  exp_dv;
    int          n_av;
    logic [159:0] act;
    logic [159:0] exp;
    reset        = rst;
    fetch_valid  = mask;
    decode_ready = rdy;
    flush        = fl;
    for (int k = 0; k < 5; k++) begin
      ents[k]  = mk(base_pc + 4 * k, bpm[k]);
      ins_i[k] = ents[k].ins;
      pc_i[k]  = ents[k].pc;
      imm_i[k] = ents[k].imm;
      pap_i[k] = ents[k].pap;
      bp_i[k]  = ents[k].bp;
      gh_i[k]  = ents[k].gh;
    end
    #1;
    exp_rdy = !rst && (mq.size() <= 11);
    n_av    = (mq.size() > 3) ? 3 : mq.size();
    for (int j = 0; j < 3; j++) exp_dv[j] = (j < n_av) && !fl && !rst;
    chk("fetch_ready", fetch_ready, exp_rdy);
    chk("decode_valid", decode_valid, exp_dv);
    if (rst) chk("occupancy_in_reset", occupancy, 0);
    for (int j = 0; j < 3; j++) begin
      act = {23'd0, ins_o[j], pc_o[j], imm_o[j], pap_o[j], bp_o[j], gh_o[j]};
      exp = exp_dv[j] ? pack(mq[j]) : '0;
      chk($sformatf("slot%0d_data", j), act, exp);
    end
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (rdy) for (int j = 0; j < n_av; j++) void'(mq.pop_front());
      if (exp_rdy) for (int k = 0; k < 5; k++) if (mask[k]) mq.push_back(ents[k]);
    end
    base_pc += 20;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_occ(input logic rst, input logic [4:0] mask, input logic [4:0] bpm,
                          input logic rdy, input logic fl, input int occ);
    step(rst, mask, bpm, rdy, fl);
    chk("occupancy", occupancy, occ);
  endtask

  function automatic vec_t v(input logic [4:0] m, input logic [4:0] b, input logic r, input int o);
    vec_t x;
    x.mask = m; x.bpm = b; x.rdy = r; x.occ = o;
    return x;
  endfunction

  initial begin
    // first bundle, then decode drains 3 then 2
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 5));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));
    // fill with decode stalled; bundles past 15 are dropped
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 5));
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 10));
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 15));
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 15));
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 15));
    // full: dequeue does not re-enable ready in the same cycle
    tbl.push_back(v(5'b11111, 5'b00000, 1'b1, 12));
    tbl.push_back(v(5'b11111, 5'b00000, 1'b1, 9));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 6));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 3));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));
    // partial and non-contiguous masks
    tbl.push_back(v(5'b00011, 5'b00010, 1'b0, 2));
    tbl.push_back(v(5'b10101, 5'b10001, 1'b0, 5));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));
    // 25 entries written so far: tail=9; advance to 14
    tbl.push_back(v(5'b11111, 5'b00000, 1'b0, 5));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));
    // wrap: entries at 14,15,0,1,2
    tbl.push_back(v(5'b11111, 5'b01010, 1'b0, 5));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));
    // simultaneous read and write
    tbl.push_back(v(5'b11111, 5'b00000, 1'b1, 5));
    tbl.push_back(v(5'b11111, 5'b00100, 1'b1, 7));
    tbl.push_back(v(5'b00111, 5'b00000, 1'b1, 7));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 4));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 1));
    tbl.push_back(v(5'b00000, 5'b00000, 1'b1, 0));

    reset = 1'b1; fetch_valid = '0; decode_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    step_occ(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b0, 0);
    step_occ(1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 0);
    base_pc = 0;

    for (int i = 0; i < tbl.size(); i++)
      step_occ(1'b0, tbl[i].mask, tbl[i].bpm, tbl[i].rdy, 1'b0, tbl[i].occ);

    // flush at count 9 with a concurrent write and read
    step_occ(1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 5);
    step_occ(1'b0, 5'b01111, 5'b00000, 1'b0, 1'b0, 9);
    step_occ(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1, 0);
    step_occ(1'b0, 5'b00011, 5'b00000, 1'b0, 1'b0, 2);
    step_occ(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 0);

    // reset mid-stream at count 7; reset also wins over a concurrent flush
    step_occ(1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 5);
    step_occ(1'b0, 5'b00011, 5'b00000, 1'b0, 1'b0, 7);
    step_occ(1'b1, 5'b11111, 5'b00000, 1'b1, 1'b1, 0);
    step_occ(1'b1, 5'b11111, 5'b00000, 1'b0, 1'b0, 0);
    step_occ(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0, 1);
    step_occ(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
